// File: rtl/supernova_free_list_ckpt.sv
// ---------------------------------------------------------------------------
// supernova_free_list_ckpt
//
// Physical-register free list for the rename stage. One instance is used per
// register class. It is a circular FIFO of free PRF tags with:
//   - sparse per-lane allocation, granted all-or-nothing;
//   - compacted, variable-count frees from commit;
//   - a bank of head-pointer checkpoints, so that a redirect can return all
//     speculatively allocated tags in a single cycle.
//
// Ports
//   clk               : clock, all state updates on the rising edge
//   rst               : synchronous active-high reset
//   alloc_req_in      : per-lane tag request (may be sparse)
//   alloc_gnt_out     : every requested lane is served this cycle
//   alloc_tag_out     : tag per lane, packed lane-major; unrequested lanes = 0
//   free_valid_in     : per-lane release mask
//   free_tag_in       : released tags, packed lane-major
//   ckpt_valid_in     : save the post-allocation head into slot ckpt_id_in
//   ckpt_id_in        : checkpoint slot to write
//   restore_valid_in  : rewind the head to slot restore_id_in
//   restore_id_in     : checkpoint slot to read
//   free_count_out    : registered number of free tags
//   overflow_err_out  : sticky; set when a free would push count past DEPTH
// ---------------------------------------------------------------------------
module supernova_free_list_ckpt #(
  parameter int NUM_PHYS    = 128,
  parameter int NUM_ARCH    = 32,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int NUM_CKPT    = 8,
  localparam int DEPTH      = NUM_PHYS - NUM_ARCH,
  localparam int TAG_W      = $clog2(NUM_PHYS),
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int CK_W       = $clog2(NUM_CKPT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_WIDTH-1:0]       alloc_req_in,
  output logic                         alloc_gnt_out,
  output logic [ALLOC_WIDTH*TAG_W-1:0] alloc_tag_out,
  input  logic [FREE_WIDTH-1:0]        free_valid_in,
  input  logic [FREE_WIDTH*TAG_W-1:0]  free_tag_in,
  input  logic                         ckpt_valid_in,
  input  logic [CK_W-1:0]              ckpt_id_in,
  input  logic                         restore_valid_in,
  input  logic [CK_W-1:0]              restore_id_in,
  output logic [CNT_W-1:0]             free_count_out,
  output logic                         overflow_err_out
);

  // Pointers are an index 0..DEPTH-1 plus a lap bit in the MSB. DEPTH need
  // not be a power of two, so wrapping is an explicit compare-and-subtract.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Index plus offset, modulo DEPTH (offset never exceeds DEPTH).
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] idx,
                                               input logic [CNT_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(DEPTH)) begin
      sum = sum - (IDX_W+1)'(DEPTH);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Pointer advance; the lap bit toggles whenever the index wraps.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [CNT_W-1:0] amt);
    logic [IDX_W:0] sum;
    ptr_t           res;
    sum = {1'b0, p[IDX_W-1:0]} + (IDX_W+1)'(amt);
    if (sum >= (IDX_W+1)'(DEPTH)) begin
      sum = sum - (IDX_W+1)'(DEPTH);
      res = {~p[IDX_W], sum[IDX_W-1:0]};
    end else begin
      res = {p[IDX_W], sum[IDX_W-1:0]};
    end
    return res;
  endfunction

  // Occupancy between a head and a tail pointer.
  function automatic logic [CNT_W-1:0] ptr_count(input ptr_t h, input ptr_t t);
    logic [CNT_W-1:0] res;
    if (h[IDX_W] == t[IDX_W]) begin
      res = CNT_W'(t[IDX_W-1:0]) - CNT_W'(h[IDX_W-1:0]);
    end else begin
      res = CNT_W'(DEPTH) - CNT_W'(h[IDX_W-1:0]) + CNT_W'(t[IDX_W-1:0]);
    end
    return res;
  endfunction

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [TAG_W-1:0] mem_reg [DEPTH];
  ptr_t             ckpt_reg [NUM_CKPT];
  ptr_t             head_reg;
  ptr_t             tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;

  // ------------------------------------------------------------------------
  // Lane compaction: each lane's offset is the number of active lanes below
  // it, so requested/freed tags occupy consecutive FIFO entries.
  // ------------------------------------------------------------------------
  logic [ALLOC_WIDTH-1:0][CNT_W-1:0] alloc_off;
  logic [FREE_WIDTH-1:0][CNT_W-1:0]  free_off;
  logic [CNT_W-1:0]                  alloc_n;
  logic [CNT_W-1:0]                  free_m;

  always_comb begin : alloc_prefix
    logic [CNT_W-1:0] run;
    run = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      alloc_off[k] = run;
      run          = run + CNT_W'(alloc_req_in[k]);
    end
    alloc_n = run;
  end

  always_comb begin : free_prefix
    logic [CNT_W-1:0] run;
    run = '0;
    for (int k = 0; k < FREE_WIDTH; k++) begin
      free_off[k] = run;
      run         = run + CNT_W'(free_valid_in[k]);
    end
    free_m = run;
  end

  // Per-lane read ports (combinational, same-cycle tags for rename).
  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
      logic [IDX_W-1:0] rd_addr;
      assign rd_addr = idx_add(head_reg[IDX_W-1:0], alloc_off[gi]);
      assign alloc_tag_out[gi*TAG_W +: TAG_W] =
        alloc_req_in[gi] ? mem_reg[rd_addr] : '0;
    end
  endgenerate

  // Per-lane write addresses.
  logic [FREE_WIDTH-1:0][IDX_W-1:0] free_addr;
  generate
    for (gi = 0; gi < FREE_WIDTH; gi++) begin : g_free_lane
      assign free_addr[gi] = idx_add(tail_reg[IDX_W-1:0], free_off[gi]);
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  logic             alloc_fire;
  logic             free_ovf;
  logic             free_accept;
  logic [CNT_W:0]   post_cnt;
  ptr_t             head_adv;
  ptr_t             head_next;
  ptr_t             tail_next;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    // Grant uses only registered count: a same-cycle free never helps.
    alloc_gnt_out = (alloc_n <= count_reg) && !restore_valid_in;
    alloc_fire    = alloc_gnt_out && (alloc_n != '0);
    head_adv      = alloc_fire ? ptr_add(head_reg, alloc_n) : head_reg;

    // The overflow test credits this cycle's grant; an overflowing free is
    // discarded as a whole rather than partially applied.
    post_cnt    = {1'b0, count_reg}
                - (alloc_fire ? {1'b0, alloc_n} : '0)
                + {1'b0, free_m};
    free_ovf    = post_cnt > (CNT_W+1)'(DEPTH);
    free_accept = !free_ovf;
    tail_next   = free_accept ? ptr_add(tail_reg, free_m) : tail_reg;

    head_next  = restore_valid_in ? ckpt_reg[restore_id_in] : head_adv;
    count_next = ptr_count(head_next, tail_next);
  end

  // ------------------------------------------------------------------------
  // Tag storage
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= TAG_W'(NUM_ARCH + i);
      end
    end else if (free_accept) begin
      for (int k = 0; k < FREE_WIDTH; k++) begin
        if (free_valid_in[k]) begin
          mem_reg[free_addr[k]] <= free_tag_in[k*TAG_W +: TAG_W];
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Pointers, count, checkpoints, error flag
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= {1'b1, {IDX_W{1'b0}}};
      count_reg <= CNT_W'(DEPTH);
      ovf_reg   <= 1'b0;
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_reg[c] <= '0;
      end
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      if (free_ovf) begin
        ovf_reg <= 1'b1;
      end
      // A checkpoint records the head after this cycle's own grant.
      if (ckpt_valid_in && !restore_valid_in) begin
        ckpt_reg[ckpt_id_in] <= head_adv;
      end
    end
  end

  assign free_count_out   = count_reg;
  assign overflow_err_out = ovf_reg;

endmodule

// File: tb/tb_supernova_free_list_ckpt.sv
module tb_supernova_free_list_ckpt;
  localparam int NP    = 128;
  localparam int NA    = 32;
  localparam int AW    = 4;
  localparam int FW    = 4;
  localparam int NC    = 8;
  localparam int DEPTH = NP - NA;
  localparam int TAG_W = 7;
  localparam int CNT_W = 7;
  localparam int CK_W  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [AW-1:0]         alloc_req;
  logic                  alloc_gnt;
  logic [AW*TAG_W-1:0]   alloc_tag;
  logic [FW-1:0]         free_valid;
  logic [FW*TAG_W-1:0]   free_tag;
  logic                  ckpt_valid;
  logic [CK_W-1:0]       ckpt_id;
  logic                  restore_valid;
  logic [CK_W-1:0]       restore_id;
  logic [CNT_W-1:0]      free_count;
  logic                  overflow_err;

  supernova_free_list_ckpt #(
    .NUM_PHYS(NP), .NUM_ARCH(NA), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW), .NUM_CKPT(NC)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req_in(alloc_req), .alloc_gnt_out(alloc_gnt), .alloc_tag_out(alloc_tag),
    .free_valid_in(free_valid), .free_tag_in(free_tag),
    .ckpt_valid_in(ckpt_valid), .ckpt_id_in(ckpt_id),
    .restore_valid_in(restore_valid), .restore_id_in(restore_id),
    .free_count_out(free_count), .overflow_err_out(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an unbounded log of every tag ever entering the list,
  // addressed by absolute position. Free tags are log[m_h .. m_t-1].
  int log_q[$];
  int m_h, m_t;
  int m_slot [NC];
  bit m_ovf;
  bit exp_gnt;
  int exp_tag [AW];

  function automatic int obs_tag(input int k);
    return int'(alloc_tag[k*TAG_W +: TAG_W]);
  endfunction

  task automatic model_reset();
    log_q.delete();
    for (int i = 0; i < DEPTH; i++) log_q.push_back(NA + i);
    m_h = 0;
    m_t = DEPTH;
    for (int c = 0; c < NC; c++) m_slot[c] = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_eval();
    int cnt, n, off;
    cnt = m_t - m_h;
    n = $countones(alloc_req);
    exp_gnt = (n <= cnt) && !restore_valid;
    off = 0;
    for (int k = 0; k < AW; k++) begin
      if (alloc_req[k]) begin
        exp_tag[k] = (m_h + off < log_q.size()) ? log_q[m_h + off] : -1;
        off++;
      end else begin
        exp_tag[k] = 0;
      end
    end
  endtask

  task automatic model_commit();
    int cnt, n, m, nh, pos, used;
    cnt = m_t - m_h;
    n = $countones(alloc_req);
    m = $countones(free_valid);
    used = exp_gnt ? n : 0;
    nh = m_h + used;
    if (cnt - used + m > DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      pos = m_t;
      for (int k = 0; k < FW; k++) begin
        if (free_valid[k]) begin
          if (pos < log_q.size()) log_q[pos] = int'(free_tag[k*TAG_W +: TAG_W]);
          else log_q.push_back(int'(free_tag[k*TAG_W +: TAG_W]));
          pos++;
        end
      end
      m_t = m_t + m;
    end
    if (ckpt_valid && !restore_valid) m_slot[ckpt_id] = nh;
    if (restore_valid) nh = m_slot[restore_id];
    m_h = nh;
  endtask

  // Drive a cycle's inputs at the falling edge, then evaluate expectations.
  task automatic apply(input logic [AW-1:0] req, input logic [FW-1:0] fv,
                       input logic [FW*TAG_W-1:0] ft, input logic ck,
                       input logic [CK_W-1:0] ckid, input logic rs,
                       input logic [CK_W-1:0] rsid);
    @(negedge clk);
    alloc_req = req; free_valid = fv; free_tag = ft;
    ckpt_valid = ck; ckpt_id = ckid; restore_valid = rs; restore_id = rsid;
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_req = '0; free_valid = '0; free_tag = '0;
    ckpt_valid = 1'b0; ckpt_id = '0; restore_valid = 1'b0; restore_id = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (free_count !== 7'd96) begin errors++; $display("FAIL reset_count got %0d want 96", free_count); end
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow_err); end
    apply(4'b1111, '0, '0, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got %0b want 1", alloc_gnt); end
    for (int k = 0; k < AW; k++) begin
      checks++;
      if (obs_tag(k) != 32 + k) begin errors++; $display("FAIL reset_tag lane%0d got %0d want %0d", k, obs_tag(k), 32 + k); end
    end
    step();
    checks++;
    if (free_count !== 7'd92) begin errors++; $display("FAIL reset_count_after got %0d want 92", free_count); end
    $display("test_reset done count=%0d", free_count);
  endtask

  task automatic test_sparse();
    do_reset();
    apply(4'b1010, '0, '0, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL sparse_gnt got %0b want 1", alloc_gnt); end
    checks++;
    if (obs_tag(0) != 0 || obs_tag(1) != 32 || obs_tag(2) != 0 || obs_tag(3) != 33) begin
      errors++;
      $display("FAIL sparse_tags got %0d,%0d,%0d,%0d want 0,32,0,33", obs_tag(0), obs_tag(1), obs_tag(2), obs_tag(3));
    end
    step();
    apply(4'b0001, '0, '0, 0, 0, 0, 0);
    checks++;
    if (obs_tag(0) != 34) begin errors++; $display("FAIL sparse_next got %0d want 34", obs_tag(0)); end
    step();
    $display("test_sparse done count=%0d", free_count);
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 23; i++) begin apply(4'b1111, '0, '0, 0, 0, 0, 0); step(); end
    apply(4'b0011, '0, '0, 0, 0, 0, 0);
    step();
    checks++;
    if (free_count !== 7'd2) begin errors++; $display("FAIL exhaust_count got %0d want 2", free_count); end
    apply(4'b0111, '0, '0, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL exhaust_gnt got %0b want 0", alloc_gnt); end
    step();
    checks++;
    if (free_count !== 7'd2) begin errors++; $display("FAIL exhaust_hold got %0d want 2", free_count); end
    apply(4'b0111, 4'b0011, {7'd0, 7'd0, 7'd33, 7'd32}, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL exhaust_nobypass got %0b want 0", alloc_gnt); end
    step();
    checks++;
    if (free_count !== 7'd4) begin errors++; $display("FAIL exhaust_freed got %0d want 4", free_count); end
    apply(4'b0111, '0, '0, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL exhaust_regrant got %0b want 1", alloc_gnt); end
    step();
    $display("test_exhaust done count=%0d", free_count);
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    apply(4'b1111, '0, '0, 0, 0, 0, 0); step();
    apply(4'b0011, '0, '0, 1, 3'd3, 0, 0); step();
    apply(4'b1111, '0, '0, 0, 0, 0, 0); step();
    apply(4'b1111, '0, '0, 0, 0, 0, 0); step();
    checks++;
    if (free_count !== 7'd82) begin errors++; $display("FAIL ckpt_pre got %0d want 82", free_count); end
    apply(4'b1111, 4'b0001, {21'd0, 7'd100}, 0, 0, 1, 3'd3);
    checks++;
    if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL ckpt_restore_gnt got %0b want 0", alloc_gnt); end
    step();
    checks++;
    if (free_count !== 7'd91) begin errors++; $display("FAIL ckpt_count got %0d want 91", free_count); end
    apply(4'b0001, '0, '0, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1 || obs_tag(0) != 38) begin
      errors++; $display("FAIL ckpt_tag got gnt=%0b tag=%0d want gnt=1 tag=38", alloc_gnt, obs_tag(0));
    end
    step();
    $display("test_ckpt_restore done count=%0d", free_count);
  endtask

  task automatic test_wrap();
    int fifo[$];
    logic [FW*TAG_W-1:0] ft;
    int want;
    do_reset();
    for (int i = 0; i < DEPTH; i++) fifo.push_back(NA + i);
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < FW; k++) ft[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, NP - 1));
      apply(4'b1111, 4'b1111, ft, 0, 0, 0, 0);
      checks++;
      if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL wrap_gnt it%0d got %0b want 1", it, alloc_gnt); end
      for (int k = 0; k < AW; k++) begin
        want = fifo.pop_front();
        checks++;
        if (obs_tag(k) != want) begin errors++; $display("FAIL wrap_tag it%0d lane%0d got %0d want %0d", it, k, obs_tag(k), want); end
      end
      for (int k = 0; k < FW; k++) fifo.push_back(int'(ft[k*TAG_W +: TAG_W]));
      step();
      checks++;
      if (free_count !== 7'd96) begin errors++; $display("FAIL wrap_count it%0d got %0d want 96", it, free_count); end
    end
    $display("test_wrap done count=%0d", free_count);
  endtask

  task automatic test_overflow();
    do_reset();
    apply('0, 4'b0001, {21'd0, 7'd5}, 0, 0, 0, 0);
    step();
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow_err); end
    checks++;
    if (free_count !== 7'd96) begin errors++; $display("FAIL ovf_count got %0d want 96", free_count); end
    apply(4'b1111, '0, '0, 0, 0, 0, 0);
    checks++;
    if (obs_tag(0) != 32 || obs_tag(3) != 35) begin errors++; $display("FAIL ovf_tags got %0d..%0d want 32..35", obs_tag(0), obs_tag(3)); end
    step();
    checks++;
    if (overflow_err !== 1'b1 || free_count !== 7'd92) begin
      errors++; $display("FAIL ovf_sticky got ovf=%0b count=%0d want 1 92", overflow_err, free_count);
    end
    do_reset();
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow_err); end
    $display("test_overflow done ovf=%0b", overflow_err);
  endtask

  task automatic test_rst_mid();
    do_reset();
    apply(4'b1111, '0, '0, 0, 0, 0, 0); step();
    apply(4'b1111, 4'b1111, 28'hABCDEF1, 1, 3'd2, 1, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (free_count !== 7'd96 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid got count=%0d ovf=%0b want 96 0", free_count, overflow_err);
    end
    apply(4'b0001, '0, '0, 0, 0, 0, 0);
    checks++;
    if (obs_tag(0) != 32) begin errors++; $display("FAIL rst_mid_tag got %0d want 32", obs_tag(0)); end
    step();
    $display("test_rst_mid done count=%0d", free_count);
  endtask

  task automatic test_random();
    logic [AW-1:0] req;
    logic [FW-1:0] fv;
    logic [FW*TAG_W-1:0] ft;
    logic ck, rs;
    logic [CK_W-1:0] ckid, rsid;
    int cnt, m, m_eff, new_t;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      cnt = m_t - m_h;
      req = AW'($urandom);
      fv = FW'($urandom);
      for (int k = 0; k < FW; k++) ft[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, NP - 1));
      if (cnt + $countones(fv) > DEPTH && $urandom_range(0, 19) != 0) fv = '0;
      m = $countones(fv);
      ck = ($urandom_range(0, 3) == 0);
      ckid = CK_W'($urandom);
      rs = ($urandom_range(0, 7) == 0);
      rsid = CK_W'($urandom);
      // Restores only to slots that are still valid against the tail.
      m_eff = (cnt + m > DEPTH) ? 0 : m;
      new_t = m_t + m_eff;
      if (rs && !(m_slot[rsid] <= new_t && new_t - m_slot[rsid] <= DEPTH)) rs = 1'b0;
      apply(req, fv, ft, ck, ckid, rs, rsid);
      checks++;
      if (alloc_gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt cyc%0d got %0b want %0b", cyc, alloc_gnt, exp_gnt); end
      if (exp_gnt) begin
        for (int k = 0; k < AW; k++) begin
          checks++;
          if (obs_tag(k) != exp_tag[k]) begin errors++; $display("FAIL rand_tag cyc%0d lane%0d got %0d want %0d", cyc, k, obs_tag(k), exp_tag[k]); end
        end
      end
      step();
      checks++;
      if (int'(free_count) != m_t - m_h || overflow_err !== m_ovf) begin
        errors++;
        $display("FAIL rand_state cyc%0d got count=%0d ovf=%0b want %0d %0b", cyc, free_count, overflow_err, m_t - m_h, m_ovf);
      end
    end
    $display("test_random done count=%0d", free_count);
  endtask

  initial begin
    rst = 1'b1;
    alloc_req = '0; free_valid = '0; free_tag = '0;
    ckpt_valid = 1'b0; ckpt_id = '0; restore_valid = 1'b0; restore_id = '0;
    test_reset();
    test_sparse();
    test_exhaust();
    test_ckpt_restore();
    test_wrap();
    test_overflow();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
